// File: rtl/apb_slave_wait_if.sv
// APB segment between the wait-state requester and this completer:
// 4-bit address, 8-bit data, single-cycle pready completion strobe.
interface apb_slave_wait_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    // Handshake: a transfer starts with one cycle of psel=1/penable=0, then holds
    // psel=1/penable=1 until the cycle where pready=1; prdata/pslverr are valid only there.
    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_wait.sv
// APB completer with a small register file and a fixed number of wait states;
// addresses at or above MEM_DEPTH complete with pslverr.
module apb_slave_wait #(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_DEPTH   = 12
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_slave_wait_if.slave   bus
);

    localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [4:0] DEPTH_LIM = 5'(MEM_DEPTH);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    // The setup cycle itself is observed from IDLE (or DONE), so it needs no state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] addr_q, addr_d;
    logic       wr_q, wr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] mem_q [MEM_DEPTH];
    logic [7:0] mem_d [MEM_DEPTH];
    logic [7:0] prdata_q, prdata_d;
    logic       pready_q, pready_d;
    logic       pslverr_q, pslverr_d;

    logic       setup_seen;
    logic       do_write;
    logic [7:0] rd_word;

    function automatic logic addr_ok(input logic [3:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    assign setup_seen  = bus.psel && !bus.penable;
    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state, transfer latch and register-file update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        do_write = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (setup_seen) begin
                    addr_d  = bus.paddr;
                    wr_d    = bus.pwrite;
                    wdata_d = bus.pwdata;
                    cnt_d   = CNT_INIT;
                    state_d = ZERO_WAIT ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.psel) begin
                    state_d = S_IDLE;
                end else if (bus.penable) begin
                    // Entering DONE on the edge the counter reaches zero puts pready in T1+WAIT_CYCLES.
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    if (cnt_q <= 4'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                do_write = bus.psel && bus.penable && wr_q && addr_ok(addr_q);
                if (setup_seen) begin
                    addr_d  = bus.paddr;
                    wr_d    = bus.pwrite;
                    wdata_d = bus.pwdata;
                    cnt_d   = CNT_INIT;
                    state_d = ZERO_WAIT ? S_DONE : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (do_write && (addr_q == 4'(i))) begin
                mem_d[i] = wdata_q;
            end
        end
    end

    // Registered outputs are computed from the state being entered.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (addr_d == 4'(i)) begin
                rd_word = mem_q[i];
            end
        end
        pready_d  = (state_d == S_DONE);
        pslverr_d = pready_d && !addr_ok(addr_d);
        prdata_d  = (pready_d && !wr_d && addr_ok(addr_d)) ? rd_word : 8'h00;
    end

endmodule

// File: tb/tb_apb_slave_wait.sv
// Directed bench for apb_slave_wait: per-cycle vector table on a WAIT_CYCLES=2 instance,
// plus hand sequences for reset corners and a WAIT_CYCLES=0 instance.
module tb_apb_slave_wait;

  localparam int WAIT2 = 2;

  logic pclk = 1'b0;
  logic presetn;

  always #5 pclk = ~pclk;

  apb_slave_wait_if bus2 ();
  apb_slave_wait_if bus0 ();

  apb_slave_wait #(.WAIT_CYCLES(2), .MEM_DEPTH(12)) dut2 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus2.slave)
  );

  apb_slave_wait #(.WAIT_CYCLES(0), .MEM_DEPTH(12)) dut0 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus0.slave)
  );

  typedef struct {
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       exp_ready;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vec_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic drive2(input logic s, input logic e, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
    bus2.psel = s; bus2.penable = e; bus2.pwrite = w; bus2.paddr = a; bus2.pwdata = d;
  endtask

  task automatic drive0(input logic s, input logic e, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
    bus0.psel = s; bus0.penable = e; bus0.pwrite = w; bus0.paddr = a; bus0.pwdata = d;
  endtask

  task automatic add_cycle(input logic s, input logic e, input logic w,
                           input logic [3:0] a, input logic [7:0] d,
                           input logic rdy, input logic err, input logic [7:0] rd);
    vec_t v;
    v.psel = s; v.penable = e; v.pwrite = w; v.addr = a; v.wdata = d;
    v.exp_ready = rdy; v.exp_err = err; v.exp_rdata = rd;
    vec_q.push_back(v);
  endtask

  // Full transfer: setup, WAIT2 wait cycles, then the completing cycle.
  task automatic add_xfer(input logic w, input logic [3:0] a, input logic [7:0] d,
                          input logic err, input logic [7:0] rd);
    add_cycle(1'b1, 1'b0, w, a, d, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < WAIT2; i++) add_cycle(1'b1, 1'b1, w, a, d, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, w, a, d, 1'b1, err, rd);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vec_q.size(); i++) begin
      @(posedge pclk);
      #1;
      drive2(vec_q[i].psel, vec_q[i].penable, vec_q[i].pwrite, vec_q[i].addr, vec_q[i].wdata);
      @(negedge pclk);
      check($sformatf("%s[%0d].pready", tag, i), {7'd0, bus2.pready}, {7'd0, vec_q[i].exp_ready});
      check($sformatf("%s[%0d].pslverr", tag, i), {7'd0, bus2.pslverr}, {7'd0, vec_q[i].exp_err});
      check($sformatf("%s[%0d].prdata", tag, i), bus2.prdata, vec_q[i].exp_rdata);
    end
    vec_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".pready2"},  {7'd0, bus2.pready},  8'h00);
    check({tag, ".pslverr2"}, {7'd0, bus2.pslverr}, 8'h00);
    check({tag, ".prdata2"},  bus2.prdata,          8'h00);
    check({tag, ".pready0"},  {7'd0, bus0.pready},  8'h00);
    check({tag, ".pslverr0"}, {7'd0, bus0.pslverr}, 8'h00);
    check({tag, ".prdata0"},  bus0.prdata,          8'h00);
  endtask

  // One W=0 cycle: drive at posedge+1, sample at the following negedge.
  task automatic cyc0(input string name, input logic s, input logic e, input logic w,
                      input logic [3:0] a, input logic [7:0] d,
                      input logic rdy, input logic err, input logic [7:0] rd);
    @(posedge pclk);
    #1;
    drive0(s, e, w, a, d);
    @(negedge pclk);
    check({name, ".pready"},  {7'd0, bus0.pready},  {7'd0, rdy});
    check({name, ".pslverr"}, {7'd0, bus0.pslverr}, {7'd0, err});
    check({name, ".prdata"},  bus0.prdata,          rd);
  endtask

  initial begin
    // Clock/reset
    presetn = 1'b0;
    drive2(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_outputs_zero("reset");
    @(posedge pclk);
    #1 presetn = 1'b1;

    // Basic write/read, error address, boundary addresses
    add_idle(1);
    add_xfer(1'b1, 4'd3, 8'hA5, 1'b0, 8'h00);
    add_xfer(1'b0, 4'd3, 8'h00, 1'b0, 8'hA5);
    add_idle(1);
    add_xfer(1'b1, 4'd13, 8'h77, 1'b1, 8'h00);
    add_xfer(1'b0, 4'd13, 8'h00, 1'b1, 8'h00);
    add_xfer(1'b1, 4'd11, 8'h99, 1'b0, 8'h00);
    add_xfer(1'b0, 4'd11, 8'h00, 1'b0, 8'h99);
    add_xfer(1'b0, 4'd12, 8'h00, 1'b1, 8'h00);
    add_xfer(1'b0, 4'd3, 8'h00, 1'b0, 8'hA5);
    // Back-to-back writes, then read both
    add_xfer(1'b1, 4'd0, 8'h11, 1'b0, 8'h00);
    add_xfer(1'b1, 4'd1, 8'h22, 1'b0, 8'h00);
    add_xfer(1'b0, 4'd0, 8'h00, 1'b0, 8'h11);
    add_xfer(1'b0, 4'd1, 8'h00, 1'b0, 8'h22);
    // Abort in the first wait cycle
    add_cycle(1'b1, 1'b0, 1'b1, 4'd5, 8'h5C, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b0, 1'b0, 1'b1, 4'd5, 8'h5C, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b0, 1'b0, 1'b1, 4'd5, 8'h5C, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b0, 1'b0, 1'b1, 4'd5, 8'h5C, 1'b0, 1'b0, 8'h00);
    add_xfer(1'b0, 4'd5, 8'h00, 1'b0, 8'h00);
    // pwdata changing during WAIT is ignored
    add_cycle(1'b1, 1'b0, 1'b1, 4'd6, 8'h3E, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, 1'b1, 4'd6, 8'hC1, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, 1'b1, 4'd6, 8'hC1, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, 1'b1, 4'd6, 8'hC1, 1'b1, 1'b0, 8'h00);
    add_xfer(1'b0, 4'd6, 8'h00, 1'b0, 8'h3E);
    // penable=1 in IDLE is ignored
    add_idle(1);
    for (int i = 0; i < 4; i++) add_cycle(1'b1, 1'b1, 1'b1, 4'd7, 8'hEE, 1'b0, 1'b0, 8'h00);
    add_idle(1);
    add_xfer(1'b0, 4'd7, 8'h00, 1'b0, 8'h00);
    // penable=0 during WAIT holds the counter for one extra cycle
    add_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h11);
    add_idle(2);
    apply_vecs("tbl");

    // Reset during a wait cycle of a write of 0xFF to addr 2
    add_cycle(1'b1, 1'b0, 1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, 8'h00);
    add_cycle(1'b1, 1'b1, 1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, 8'h00);
    apply_vecs("rst_wait");
    #1 presetn = 1'b0;
    #1 check_outputs_zero("rst_wait_now");
    @(posedge pclk);
    #1 presetn = 1'b1;
    drive2(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    add_idle(1);
    add_xfer(1'b0, 4'd2, 8'h00, 1'b0, 8'h00);
    add_xfer(1'b0, 4'd3, 8'h00, 1'b0, 8'h00);
    apply_vecs("after_rst");

    // Reset in the completing cycle of a read clears the registered outputs at once
    add_xfer(1'b1, 4'd4, 8'h5A, 1'b0, 8'h00);
    add_xfer(1'b0, 4'd4, 8'h00, 1'b0, 8'h5A);
    apply_vecs("rst_done");
    #1 presetn = 1'b0;
    #1 check_outputs_zero("rst_done_now");
    @(posedge pclk);
    #1 presetn = 1'b1;
    drive2(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    add_idle(1);
    add_xfer(1'b0, 4'd4, 8'h00, 1'b0, 8'h00);
    apply_vecs("after_rst2");

    // WAIT_CYCLES=0 instance: pready in T1
    cyc0("w0_idle",   1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00);
    cyc0("w0_wr_t0",  1'b1, 1'b0, 1'b1, 4'd11, 8'h3C, 1'b0, 1'b0, 8'h00);
    cyc0("w0_wr_t1",  1'b1, 1'b1, 1'b1, 4'd11, 8'h3C, 1'b1, 1'b0, 8'h00);
    cyc0("w0_rd_t0",  1'b1, 1'b0, 1'b0, 4'd11, 8'h00, 1'b0, 1'b0, 8'h00);
    cyc0("w0_rd_t1",  1'b1, 1'b1, 1'b0, 4'd11, 8'h00, 1'b1, 1'b0, 8'h3C);
    cyc0("w0_err_t0", 1'b1, 1'b0, 1'b0, 4'd12, 8'h00, 1'b0, 1'b0, 8'h00);
    cyc0("w0_err_t1", 1'b1, 1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 1'b1, 8'h00);
    cyc0("w0_end",    1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/apb_slave_wait.md
Name: apb_slave_wait

Overview:
- APB completer (slave) that pairs with the team's wait-state APB requester.
- Contains a 12-entry x 8-bit register file and inserts a fixed, parameterised number of wait states by holding pready low.
- Flags out-of-range addresses with pslverr.
- Sits on the same 4-bit-address / 8-bit-data APB segment as the requester. It is the reference target for requester verification and the template for peripheral register blocks.

Parameters:
- WAIT_CYCLES, 2, number of access-phase cycles with pready=0 before the completing cycle (legal range 0..15).
- MEM_DEPTH, 12, number of implemented registers. Addresses 0..MEM_DEPTH-1 are valid; MEM_DEPTH..15 are error addresses.

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- psel  in  1  slave select
- penable  in  1  access-phase indicator
- pwrite  in  1  1=write, 0=read
- paddr  in  4  register address
- pwdata  in  8  write data
- prdata  out  8  read data, valid only when pready=1
- pready  out  1  transfer-complete strobe
- pslverr  out  1  error response, valid only when pready=1

Behaviour:
- Reset: presetn is asynchronous, active-low; clock is pclk. In reset, prdata=0x00, pready=0, pslverr=0, all register-file entries=0x00, FSM=IDLE, wait counter=0.
- FSM states:
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP: the cycle in which psel=1, penable=0 is observed. At its closing edge, latch paddr, pwrite and pwdata, load counter=WAIT_CYCLES, then go to WAIT.
  - WAIT -> DONE when counter reaches 0. Counter decrements once per cycle while psel=1 and penable=1.
  - DONE: one cycle with pready=1. Then go to SETUP if psel=1 and penable=0 (back-to-back transfer), else IDLE.
- Outputs are registered. pready is set on the edge that enters DONE and cleared on the following edge, so it is high for exactly one cycle per transfer.
- Latency: the first access cycle is T1 (setup is T0). pready is high in access cycle T1+WAIT_CYCLES.
  - WAIT_CYCLES=0: pready is high in T1. WAIT goes straight to DONE, with pready set at the end of T0.
- Reads: prdata = mem[latched addr], driven in the DONE cycle. prdata is 0x00 in every other cycle.
- Writes: mem[latched addr] <= latched pwdata on the closing edge of the DONE cycle, only if psel=1, penable=1 and the address is valid.
  - The data used is the data latched in SETUP. pwdata changes during WAIT are ignored.
- Error addresses (paddr >= MEM_DEPTH): the same wait count applies. In the DONE cycle pslverr=1 and prdata=0x00, and no register is written. pslverr=0 for valid addresses and outside DONE.
- Abort: if psel=0 in any WAIT or DONE cycle, return to IDLE on that edge. pready, pslverr and prdata go to 0 and no write occurs.
- Protocol violations:
  - penable=1 while in IDLE is ignored; the FSM stays in IDLE.
  - penable=0 while in WAIT: the counter holds, and the FSM stays in WAIT.
- Reset mid-transfer: all outputs are forced to reset values immediately, and any pending write is dropped.
- Counter width is 4 bits. The counter never underflows: a decrement is only applied when the counter is nonzero.

Test Plan:
- Reset, then write 0xA5 to addr 3 (WAIT_CYCLES=2) -> pready=0 in T1 and T2, pready=1 in T3 with pslverr=0; a following read of addr 3 returns prdata=0xA5 in its completing cycle, and prdata=0x00 in its wait cycles.
- Read addr 13 -> pready=1 after 2 wait cycles with pslverr=1 and prdata=0x00. A prior write of 0x77 to addr 13 has no effect, and addresses 0..11 are unchanged.
- Back-to-back: write 0x11 to addr 0, then immediately (setup in the cycle after pready) write 0x22 to addr 1, then read both -> 0x11 and 0x22. Each transfer shows exactly one pready pulse.
- Abort: start a write of 0x5C to addr 5, then drop psel in the first wait cycle -> pready is never asserted, the FSM returns to IDLE, and a later read of addr 5 returns 0x00.
- WAIT_CYCLES=0 build: a write of 0x3C to addr 11 completes with pready=1 in T1, and a read of addr 11 returns 0x3C.
- Reset asserted during a wait cycle of a write of 0xFF to addr 2 -> pready/prdata/pslverr go to 0 immediately, and a read of addr 2 after reset returns 0x00.
